bcd_operand_entry: RTL and testbench



---
 rtl/bcd_operand_entry_if.sv | 31 +++
 rtl/bcd_operand_entry.sv | 161 ++++++++++++++++
 tb/tb_bcd_operand_entry.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_operand_entry_if.sv
// Operand-entry bus: switches and raw keys in, latched operand word and status out.
// KEY_BACK exists only when BCD_ENTRY_BACKSPACE_EN is defined.
interface bcd_operand_entry_if;
  logic [3:0]  DIGIT_IN;
  logic        OP_SEL;
  logic        KEY_ENTER;
  logic        KEY_CLEAR;
`ifdef BCD_ENTRY_BACKSPACE_EN
  logic        KEY_BACK;
`endif
  logic [16:0] OPERANDS;
  logic        VALID;
  logic [3:0]  CURSOR;
  logic        DIGIT_ERR;

  modport master (
`ifdef BCD_ENTRY_BACKSPACE_EN
    output KEY_BACK,
`endif
    output DIGIT_IN, OP_SEL, KEY_ENTER, KEY_CLEAR,
    input  OPERANDS, VALID, CURSOR, DIGIT_ERR
  );

  modport slave (
`ifdef BCD_ENTRY_BACKSPACE_EN
    input  KEY_BACK,
`endif
    input  DIGIT_IN, OP_SEL, KEY_ENTER, KEY_CLEAR,
    output OPERANDS, VALID, CURSOR, DIGIT_ERR
  );
endinterface

// File: rtl/bcd_operand_entry.sv
// Debounced pushbutton entry of two 2-digit BCD operands plus operator.
// Optional backspace key enabled by defining BCD_ENTRY_BACKSPACE_EN.
module bcd_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  bcd_operand_entry_if.slave bus
);
`ifdef BCD_ENTRY_BACKSPACE_EN
  localparam int NK = 3;
`else
  localparam int NK = 2;
`endif
  localparam int K_ENTER = 0;
  localparam int K_CLEAR = 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_A_TENS, S_A_ONES, S_B_TENS, S_B_ONES, S_DONE
  } state_t;

  logic [NK-1:0]    key_raw;
  logic [NK-1:0]    sync1_q, sync2_q, stable_q, armed_q, press_q;
  logic [CNT_W-1:0] cnt_q [NK];

  state_t      state_q, state_d;
  logic [15:0] digits_q, digits_d;
  logic        op_q, op_d, valid_q, valid_d, err_q, err_d;
  logic        enter_p, clear_p;
  logic [3:0]  cursor;

  assign key_raw[K_ENTER] = bus.KEY_ENTER;
  assign key_raw[K_CLEAR] = bus.KEY_CLEAR;
`ifdef BCD_ENTRY_BACKSPACE_EN
  logic back_p;
  assign key_raw[2] = bus.KEY_BACK;
  assign back_p     = press_q[2];
`endif
  assign enter_p = press_q[K_ENTER];
  assign clear_p = press_q[K_CLEAR];

  // Synchronizers reset to "pressed" and a key is armed only after it has been
  // seen released, so a key held through reset never yields a press.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '1;
      armed_q  <= '0;
      press_q  <= '0;
      for (int k = 0; k < NK; k++) cnt_q[k] <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      armed_q <= armed_q | sync2_q;
      press_q <= '0;
      for (int k = 0; k < NK; k++) begin
        if (sync2_q[k] == stable_q[k]) begin
          cnt_q[k] <= '0;
        end else if (cnt_q[k] == CNT_LAST) begin
          stable_q[k] <= sync2_q[k];
          cnt_q[k]    <= '0;
          press_q[k]  <= stable_q[k] & armed_q[k];
        end else begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_A_TENS;
      digits_q <= '0;
      op_q     <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      op_q     <= op_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // Priority: CLEAR, then BACK (when built in), then ENTER.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    op_d     = op_q;
    valid_d  = valid_q;
    err_d    = err_q;
    if (clear_p) begin
      state_d  = S_A_TENS;
      digits_d = '0;
      op_d     = 1'b0;
      valid_d  = 1'b0;
      err_d    = 1'b0;
    end
`ifdef BCD_ENTRY_BACKSPACE_EN
    else if (back_p) begin
      case (state_q)
        S_A_ONES: begin state_d = S_A_TENS; digits_d[15:12] = 4'd0; err_d = 1'b0; end
        S_B_TENS: begin state_d = S_A_ONES; digits_d[11:8]  = 4'd0; err_d = 1'b0; end
        S_B_ONES: begin state_d = S_B_TENS; digits_d[7:4]   = 4'd0; err_d = 1'b0; end
        S_DONE: begin
          state_d        = S_B_ONES;
          digits_d[3:0]  = 4'd0;
          op_d           = 1'b0;
          valid_d        = 1'b0;
          err_d          = 1'b0;
        end
        default: ;
      endcase
    end
`endif
    else if (enter_p) begin
      if (state_q == S_DONE) begin
        state_d  = S_A_TENS;
        digits_d = '0;
        op_d     = 1'b0;
        valid_d  = 1'b0;
      end else if (bus.DIGIT_IN > 4'd9) begin
        err_d = 1'b1;
      end else begin
        err_d = 1'b0;
        case (state_q)
          S_A_TENS: begin digits_d[15:12] = bus.DIGIT_IN; state_d = S_A_ONES; end
          S_A_ONES: begin digits_d[11:8]  = bus.DIGIT_IN; state_d = S_B_TENS; end
          S_B_TENS: begin digits_d[7:4]   = bus.DIGIT_IN; state_d = S_B_ONES; end
          S_B_ONES: begin
            digits_d[3:0] = bus.DIGIT_IN;
            op_d          = bus.OP_SEL;
            valid_d       = 1'b1;
            state_d       = S_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    cursor = 4'b0000;
    case (state_q)
      S_A_TENS: cursor = 4'b1000;
      S_A_ONES: cursor = 4'b0100;
      S_B_TENS: cursor = 4'b0010;
      S_B_ONES: cursor = 4'b0001;
      default:  cursor = 4'b0000;
    endcase
  end

  assign bus.OPERANDS  = {op_q, digits_q};
  assign bus.VALID     = valid_q;
  assign bus.CURSOR    = cursor;
  assign bus.DIGIT_ERR = err_q;
endmodule

// File: tb/tb_bcd_operand_entry.sv
// Directed bench for bcd_operand_entry with a short debounce window.
module tb_bcd_operand_entry;
  localparam int D = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bcd_operand_entry_if bus_if();

  bcd_operand_entry #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .CLOCK_50(clk),
    .RESET_N (rst_n),
    .bus     (bus_if)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        clr;
    logic [3:0]  d;
    logic        op;
    logic [16:0] ops;
    logic        v;
    logic [3:0]  cur;
    logic        err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string nm, input logic [16:0] ops, input logic v,
                            input logic [3:0] cur, input logic err);
    @(negedge clk);
    chk({nm, ".ops"}, 32'(bus_if.OPERANDS), 32'(ops));
    chk({nm, ".valid"}, 32'(bus_if.VALID), 32'(v));
    chk({nm, ".cursor"}, 32'(bus_if.CURSOR), 32'(cur));
    chk({nm, ".err"}, 32'(bus_if.DIGIT_ERR), 32'(err));
  endtask

  task automatic press(input int k);
    if (k == 0) bus_if.KEY_ENTER = 1'b0;
    else if (k == 1) bus_if.KEY_CLEAR = 1'b0;
`ifdef BCD_ENTRY_BACKSPACE_EN
    else bus_if.KEY_BACK = 1'b0;
`endif
    cyc(D + 8);
    bus_if.KEY_ENTER = 1'b1;
    bus_if.KEY_CLEAR = 1'b1;
`ifdef BCD_ENTRY_BACKSPACE_EN
    bus_if.KEY_BACK = 1'b1;
`endif
    cyc(D + 8);
  endtask

  task automatic enter(input logic [3:0] d, input logic op);
    bus_if.DIGIT_IN = d;
    bus_if.OP_SEL   = op;
    press(0);
  endtask

  vec_t vecs [14];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0]  = '{1'b0, 4'd4,  1'b0, 17'h04000, 1'b0, 4'b0100, 1'b0};
    vecs[1]  = '{1'b0, 4'd7,  1'b0, 17'h04700, 1'b0, 4'b0010, 1'b0};
    vecs[2]  = '{1'b0, 4'd2,  1'b0, 17'h04720, 1'b0, 4'b0001, 1'b0};
    vecs[3]  = '{1'b0, 4'd5,  1'b0, 17'h04725, 1'b1, 4'b0000, 1'b0};
    vecs[4]  = '{1'b0, 4'd9,  1'b1, 17'h00000, 1'b0, 4'b1000, 1'b0};
    vecs[5]  = '{1'b0, 4'd12, 1'b0, 17'h00000, 1'b0, 4'b1000, 1'b1};
    vecs[6]  = '{1'b0, 4'd3,  1'b0, 17'h03000, 1'b0, 4'b0100, 1'b0};
    vecs[7]  = '{1'b0, 4'd12, 1'b0, 17'h03000, 1'b0, 4'b0100, 1'b1};
    vecs[8]  = '{1'b0, 4'd9,  1'b0, 17'h03900, 1'b0, 4'b0010, 1'b0};
    vecs[9]  = '{1'b0, 4'd8,  1'b0, 17'h03980, 1'b0, 4'b0001, 1'b0};
    vecs[10] = '{1'b0, 4'd6,  1'b1, 17'h13986, 1'b1, 4'b0000, 1'b0};
    vecs[11] = '{1'b1, 4'd0,  1'b0, 17'h00000, 1'b0, 4'b1000, 1'b0};
    vecs[12] = '{1'b0, 4'd15, 1'b0, 17'h00000, 1'b0, 4'b1000, 1'b1};
    vecs[13] = '{1'b1, 4'd0,  1'b0, 17'h00000, 1'b0, 4'b1000, 1'b0};

    bus_if.DIGIT_IN  = 4'd0;
    bus_if.OP_SEL    = 1'b0;
    bus_if.KEY_ENTER = 1'b1;
    bus_if.KEY_CLEAR = 1'b1;
`ifdef BCD_ENTRY_BACKSPACE_EN
    bus_if.KEY_BACK  = 1'b1;
`endif
    #3 rst_n = 1'b0;
    #20;
    check_outs("reset", 17'h0, 1'b0, 4'b1000, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(D + 6);

    for (int i = 0; i < 14; i++) begin
      bus_if.DIGIT_IN = vecs[i].d;
      bus_if.OP_SEL   = vecs[i].op;
      press(vecs[i].clr ? 1 : 0);
      check_outs($sformatf("vec%0d", i), vecs[i].ops, vecs[i].v, vecs[i].cur, vecs[i].err);
    end

    // Key-edge to stored-digit latency: two sync cycles, debounce window, one write.
    bus_if.DIGIT_IN = 4'd5;
    bus_if.KEY_ENTER = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (bus_if.CURSOR != 4'b1000) break;
    end
    chk("latency", 32'(n), 32'(D + 3));
    cyc(D + 8);
    bus_if.KEY_ENTER = 1'b1;
    cyc(D + 8);
    check_outs("latency_hold", 17'h05000, 1'b0, 4'b0100, 1'b0);
    press(1);

    // Bouncing ENTER yields a single accept.
    bus_if.DIGIT_IN = 4'd3;
    for (int i = 0; i < 3; i++) begin
      bus_if.KEY_ENTER = ~bus_if.KEY_ENTER;
      cyc(1);
    end
    bus_if.KEY_ENTER = 1'b0;
    cyc(10);
    bus_if.KEY_ENTER = 1'b1;
    cyc(D + 10);
    check_outs("bounce", 17'h03000, 1'b0, 4'b0100, 1'b0);
    press(1);

    // Operator frozen after DONE; ENTER in DONE clears.
    enter(4'd1, 1'b1); enter(4'd2, 1'b1); enter(4'd3, 1'b1); enter(4'd4, 1'b1);
    bus_if.OP_SEL = 1'b0;
    cyc(5);
    check_outs("op_hold", 17'h11234, 1'b1, 4'b0000, 1'b0);
    enter(4'd7, 1'b0);
    check_outs("done_enter", 17'h0, 1'b0, 4'b1000, 1'b0);

    // CLEAR and ENTER together in B_TENS: CLEAR wins.
    enter(4'd1, 1'b0); enter(4'd2, 1'b0);
    bus_if.DIGIT_IN  = 4'd5;
    bus_if.KEY_ENTER = 1'b0;
    bus_if.KEY_CLEAR = 1'b0;
    cyc(D + 8);
    bus_if.KEY_ENTER = 1'b1;
    bus_if.KEY_CLEAR = 1'b1;
    cyc(D + 8);
    check_outs("clr_vs_enter", 17'h0, 1'b0, 4'b1000, 1'b0);

    // Reset mid-debounce with the key still held: no digit stored afterwards.
    enter(4'd7, 1'b0);
    bus_if.DIGIT_IN  = 4'd8;
    bus_if.KEY_ENTER = 1'b0;
    cyc(3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.ops", 32'(bus_if.OPERANDS), 32'h0);
    chk("rst_mid.cursor", 32'(bus_if.CURSOR), 32'h8);
    #3 rst_n = 1'b1;
    cyc(D + 12);
    check_outs("rst_held", 17'h0, 1'b0, 4'b1000, 1'b0);
    bus_if.KEY_ENTER = 1'b1;
    cyc(D + 8);
    enter(4'd6, 1'b0);
    check_outs("post_rst", 17'h06000, 1'b0, 4'b0100, 1'b0);
    press(1);

`ifdef BCD_ENTRY_BACKSPACE_EN
    enter(4'd1, 1'b1); enter(4'd2, 1'b1); enter(4'd3, 1'b1); enter(4'd4, 1'b1);
    check_outs("bs_full", 17'h11234, 1'b1, 4'b0000, 1'b0);
    press(2);
    check_outs("bs_done", 17'h01230, 1'b0, 4'b0001, 1'b0);
    press(2);
    check_outs("bs_bones", 17'h01200, 1'b0, 4'b0010, 1'b0);
    press(1);
    press(2);
    check_outs("bs_atens", 17'h0, 1'b0, 4'b1000, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
